// File: rtl/vga_fb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_fetch_ctrl
//  Brief    : Framebuffer fetch scheduler: paces Avalon-MM burst reads into the
//             VGA pixel FIFO by FIFO room, restarts each frame with a tear-free
//             base-address flip, and exposes an 8-bit-addressed CSR slave.
//             Optional build macro: VGA_FB_IRQ_EN (frame-done interrupt, CSR 0x04).
//  Revision : 1.0  initial release
// ============================================================================
module vga_fb_fetch_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 16,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          csr_read,
    input  logic                          csr_write,
    input  logic [7:0]                    csr_addr,
    input  logic [31:0]                   csr_wr_data,
    output logic [31:0]                   csr_rd_data,
    output logic [ADDR_W-1:0]             av_address,
    output logic                          av_read,
    output logic [7:0]                    av_burstcount,
    input  logic                          av_waitrequest,
    input  logic [DATA_W-1:0]             av_readdata,
    input  logic                          av_readdatavalid,
    input  logic                          frame_start,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_used,
    output logic                          fifo_wr,
    output logic [DATA_W-1:0]             fifo_wdata,
    output logic                          fifo_flush,
    input  logic                          pix_underflow
`ifdef VGA_FB_IRQ_EN
    ,
    output logic                          irq
`endif
);

    localparam int c_TOTAL     = H_ACTIVE * V_ACTIVE;
    localparam int c_WC_W      = $clog2(c_TOTAL + 1);
    localparam int c_FU_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int c_PEND_W    = c_FU_W + 1;
    localparam int c_SUM_W     = c_FU_W + 2;
    localparam int c_ALIGN_W   = $clog2(BURST_LEN * DATA_W / 8);

    localparam logic [c_WC_W-1:0]   c_TOTAL_WC  = c_WC_W'(c_TOTAL);
    localparam logic [c_WC_W-1:0]   c_BURST_WC  = c_WC_W'(BURST_LEN);
    localparam logic [c_PEND_W-1:0] c_BURST_P   = c_PEND_W'(BURST_LEN);
    localparam logic [c_PEND_W-1:0] c_ONE_P     = c_PEND_W'(1);
    localparam logic [c_SUM_W-1:0]  c_BURST_S   = c_SUM_W'(BURST_LEN);
    localparam logic [c_SUM_W-1:0]  c_DEPTH_S   = c_SUM_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0]   c_ADDR_INC  = ADDR_W'(BURST_LEN * DATA_W / 8);
    localparam logic [ADDR_W-1:0]   c_BASE_MASK = {ADDR_W{1'b1}} << c_ALIGN_W;

    localparam logic [7:0] c_A_CTRL   = 8'h00;
    localparam logic [7:0] c_A_BASE   = 8'h01;
    localparam logic [7:0] c_A_STATUS = 8'h02;
    localparam logic [7:0] c_A_FCNT   = 8'h03;
`ifdef VGA_FB_IRQ_EN
    localparam logic [7:0] c_A_IRQ    = 8'h04;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_ROOM  = 3'd2,
        S_REQ   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_WC_W-1:0]   r_word_cnt;
    logic [c_PEND_W-1:0] r_pend;
    logic                r_frame_counted;
    logic [31:0]         r_frame_cnt;
    logic                r_enable;
    logic [ADDR_W-1:0]   r_fb_base;
    logic                r_underflow;

    logic                w_grant;
    logic                w_dec;
    logic [c_PEND_W-1:0] w_pend_nxt;
    logic                w_room;
    logic                w_restart;
    logic                w_frame_done;
    logic                w_busy;
    logic [31:0]         w_rd_mux;

    assign w_grant    = av_read & ~av_waitrequest;
    // A return with nothing outstanding is a slave protocol error; never let pend wrap.
    assign w_dec      = av_readdatavalid & ((r_pend != '0) | w_grant);
    assign w_pend_nxt = r_pend + (w_grant ? c_BURST_P : '0) - (w_dec ? c_ONE_P : '0);
    assign w_room     = ({2'b00, fifo_used} + {1'b0, r_pend} + c_BURST_S) <= c_DEPTH_S;
    assign w_restart  = frame_start & ((r_state != S_IDLE) | r_enable);
    assign w_frame_done = (r_state == S_DONE) & (r_pend == '0) & ~r_frame_counted & ~w_restart;
    assign w_busy     = (r_state != S_IDLE);

    assign av_burstcount = 8'(BURST_LEN);
    assign fifo_wr       = av_readdatavalid & (r_state != S_FLUSH);
    assign fifo_wdata    = av_readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_word_cnt      <= '0;
            r_pend          <= '0;
            r_frame_counted <= 1'b0;
            r_frame_cnt     <= '0;
            av_read         <= 1'b0;
            av_address      <= '0;
            fifo_flush      <= 1'b0;
        end else begin
            r_pend     <= w_pend_nxt;
            fifo_flush <= 1'b0;
            if (w_restart) begin
                // Drop any ungranted request; beats already in flight are discarded in FLUSH.
                r_state <= S_FLUSH;
                av_read <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        av_read <= 1'b0;
                    end
                    S_FLUSH: begin
                        if (r_pend == '0) begin
                            fifo_flush      <= 1'b1;
                            r_addr          <= r_fb_base;
                            r_word_cnt      <= '0;
                            r_frame_counted <= 1'b0;
                            r_state         <= S_ROOM;
                        end
                    end
                    S_ROOM: begin
                        if (!r_enable && (r_pend == '0)) begin
                            r_state <= S_IDLE;
                        end else if (r_word_cnt == c_TOTAL_WC) begin
                            r_state <= S_DONE;
                        end else if (r_enable && w_room) begin
                            av_read    <= 1'b1;
                            av_address <= r_addr;
                            r_state    <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (w_grant) begin
                            av_read    <= 1'b0;
                            r_addr     <= r_addr + c_ADDR_INC;
                            r_word_cnt <= r_word_cnt + c_BURST_WC;
                            r_state    <= S_ROOM;
                        end
                    end
                    S_DONE: begin
                        if (w_frame_done) begin
                            r_frame_counted <= 1'b1;
                            r_frame_cnt     <= r_frame_cnt + 32'd1;
                        end
                    end
                    default: begin
                        av_read <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // FB_BASE is only a pending value; the fetch engine samples it on FLUSH exit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable    <= 1'b0;
            r_fb_base   <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (csr_write && (csr_addr == c_A_CTRL)) begin
                r_enable <= csr_wr_data[0];
            end
            if (csr_write && (csr_addr == c_A_BASE)) begin
                r_fb_base <= ADDR_W'(csr_wr_data) & c_BASE_MASK;
            end
            if (pix_underflow) begin
                r_underflow <= 1'b1;
            end else if (csr_write && (csr_addr == c_A_STATUS) && csr_wr_data[1]) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef VGA_FB_IRQ_EN
    logic r_irq_en;
    logic r_irq_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en   <= 1'b0;
            r_irq_pend <= 1'b0;
        end else begin
            if (csr_write && (csr_addr == c_A_IRQ)) begin
                r_irq_en <= csr_wr_data[0];
            end
            if (w_frame_done) begin
                r_irq_pend <= 1'b1;
            end else if (csr_write && (csr_addr == c_A_IRQ) && csr_wr_data[1]) begin
                r_irq_pend <= 1'b0;
            end
        end
    end

    assign irq = r_irq_en & r_irq_pend;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (csr_addr)
            c_A_CTRL:   w_rd_mux = {31'd0, r_enable};
            c_A_BASE:   w_rd_mux = 32'(r_fb_base);
            c_A_STATUS: w_rd_mux = {30'd0, r_underflow, w_busy};
            c_A_FCNT:   w_rd_mux = r_frame_cnt;
`ifdef VGA_FB_IRQ_EN
            c_A_IRQ:    w_rd_mux = {30'd0, r_irq_pend, r_irq_en};
`endif
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_rd_data <= '0;
        end else begin
            csr_rd_data <= csr_read ? w_rd_mux : 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_fb_fetch_ctrl
//  Brief    : Scoreboard bench: Avalon slave model with burst-address and
//             return-data queues, CSR accesses, frame restart and pacing cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_fb_fetch_ctrl;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BURST_LEN  = 8;
    localparam int H_ACTIVE   = 32;
    localparam int V_ACTIVE   = 2;
    localparam int FIFO_DEPTH = 32;
    localparam int FU_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int BURSTS     = H_ACTIVE * V_ACTIVE / BURST_LEN;
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * DATA_W / 8);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              csr_read, csr_write;
    logic [7:0]        csr_addr;
    logic [31:0]       csr_wr_data, csr_rd_data;
    logic [ADDR_W-1:0] av_address;
    logic              av_read;
    logic [7:0]        av_burstcount;
    logic              av_waitrequest;
    logic [DATA_W-1:0] av_readdata;
    logic              av_readdatavalid;
    logic              frame_start;
    logic [FU_W-1:0]   fifo_used;
    logic              fifo_wr;
    logic [DATA_W-1:0] fifo_wdata;
    logic              fifo_flush;
    logic              pix_underflow;

    vga_fb_fetch_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .csr_read(csr_read), .csr_write(csr_write), .csr_addr(csr_addr),
        .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data),
        .av_address(av_address), .av_read(av_read), .av_burstcount(av_burstcount),
        .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
        .av_readdatavalid(av_readdatavalid),
        .frame_start(frame_start), .fifo_used(fifo_used),
        .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_flush(fifo_flush),
        .pix_underflow(pix_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          epoch;
        int          ready;
    } beat_t;

    beat_t       ret_q[$];
    logic [31:0] addr_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0, epoch = 0, grants_ep = 0;
    int          disc_cnt = 0, wr_cnt = 0, flush_cnt = 0;
    int          stall = 0, lat = 2;
    bit          fs_prev = 1'b0, hold_v = 1'b0, single_chk = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [31:0] fb_shadow = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Avalon slave + scoreboard; acts 1 time unit after each falling edge.
    initial begin : p_slave
        beat_t b;
        logic  wexp;
        av_waitrequest   = 1'b0;
        av_readdatavalid = 1'b0;
        av_readdata      = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            // A frame_start seen last cycle has now been taken: old beats become stale.
            if (fs_prev) begin
                epoch++;
                grants_ep = 0;
                addr_q.delete();
                for (int i = 0; i < BURSTS; i++) addr_q.push_back(fb_shadow + 32'(i) * BURST_BYTES);
            end
            fs_prev = frame_start;
            if (fifo_flush) flush_cnt++;
            if (hold_v) begin
                check_val("hold_read", {31'd0, av_read}, 32'd1);
                check_val("hold_addr", av_address, hold_addr);
            end
            hold_v         = 1'b0;
            av_waitrequest = 1'b0;
            if (av_read) begin
                if (stall > 0) begin
                    stall--;
                    av_waitrequest = 1'b1;
                    hold_v         = 1'b1;
                    hold_addr      = av_address;
                end else begin
                    if (addr_q.size() == 0) check_val("burst_extra", 32'(grants_ep), 32'(BURSTS - 1));
                    else check_val("burst_addr", av_address, addr_q.pop_front());
                    if (single_chk) check_val("pend_at_grant", 32'(ret_q.size()), 32'd0);
                    for (int k = 0; k < BURST_LEN; k++) begin
                        b.data  = (av_address + 32'(4 * k)) ^ 32'hA5A5_0000;
                        b.epoch = epoch;
                        b.ready = cyc + lat;
                        ret_q.push_back(b);
                    end
                    grants_ep++;
                end
            end
            if (ret_q.size() > 0 && ret_q[0].ready <= cyc) begin
                b = ret_q.pop_front();
                av_readdatavalid = 1'b1;
                av_readdata      = b.data;
                #1;
                wexp = (b.epoch == epoch);
                check_val("fifo_wr", {31'd0, fifo_wr}, {31'd0, wexp});
                if (wexp) check_val("fifo_wdata", fifo_wdata, b.data);
                else disc_cnt++;
                if (fifo_wr) wr_cnt++;
            end else begin
                av_readdatavalid = 1'b0;
                av_readdata      = '0;
                #1;
                check_val("fifo_wr_idle", {31'd0, fifo_wr}, 32'd0);
            end
        end
    end

    task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_write = 1'b1; csr_addr = a; csr_wr_data = d;
        if (a == 8'h01) fb_shadow = d & ~(BURST_BYTES - 32'd1);
        @(negedge clk);
        csr_write = 1'b0;
    endtask

    task automatic csr_rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk);
        csr_read = 1'b1; csr_addr = a;
        @(negedge clk);
        csr_read = 1'b0;
        check_val(tag, csr_rd_data, exp);
    endtask

    task automatic pulse_fs();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(grants_ep == BURSTS && ret_q.size() == 0) && n < 600);
        check_val(tag, 32'(grants_ep == BURSTS && ret_q.size() == 0), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_outstanding(input string tag, input int lo, input int hi);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ret_q.size() >= lo && ret_q.size() <= hi) && n < 300);
        check_val(tag, 32'(ret_q.size() >= lo && ret_q.size() <= hi), 32'd1);
    endtask

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        int seen;
        int d0;
        reset_n = 1'b0; csr_read = 1'b0; csr_write = 1'b0; csr_addr = '0; csr_wr_data = '0;
        frame_start = 1'b0; fifo_used = '0; pix_underflow = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_av_read",    {31'd0, av_read},    32'd0);
        check_val("rst_av_address", av_address,          32'd0);
        check_val("rst_fifo_flush", {31'd0, fifo_flush}, 32'd0);
        check_val("rst_csr_rd",     csr_rd_data,         32'd0);
        check_val("burstcount",     {24'd0, av_burstcount}, 32'd8);
        reset_n = 1'b1;

        csr_rd_chk("rst_status", 8'h02, 32'd0);
        csr_rd_chk("rst_fcnt",   8'h03, 32'd0);
        csr_rd_chk("rst_ctrl",   8'h00, 32'd0);
        csr_wr(8'h01, 32'h0000_1007);
        csr_rd_chk("base_align", 8'h01, 32'h0000_1000);
        csr_wr(8'h05, 32'hFFFF_FFFF);
        csr_rd_chk("unmapped_05", 8'h05, 32'd0);
        csr_rd_chk("unmapped_04", 8'h04, 32'd0);
        csr_wr(8'h00, 32'd1);
        csr_rd_chk("ctrl_en", 8'h00, 32'd1);

        // Frame 1: zero-wait slave, base 0x1000.
        pulse_fs();
        wait_frame("f1_done");
        check_val("f1_wr_cnt", 32'(wr_cnt), 32'd64);
        check_val("f1_flush",  32'(flush_cnt), 32'd1);
        csr_rd_chk("f1_fcnt",   8'h03, 32'd1);
        csr_rd_chk("f1_status", 8'h02, 32'd1);

        // Underflow sticky bit, W1C, and set-wins-over-clear.
        @(negedge clk); pix_underflow = 1'b1;
        @(negedge clk); pix_underflow = 1'b0;
        csr_rd_chk("uf_set", 8'h02, 32'd3);
        @(negedge clk);
        pix_underflow = 1'b1; csr_write = 1'b1; csr_addr = 8'h02; csr_wr_data = 32'd2;
        @(negedge clk);
        pix_underflow = 1'b0; csr_write = 1'b0;
        csr_rd_chk("uf_setwins", 8'h02, 32'd3);
        csr_wr(8'h02, 32'd2);
        csr_rd_chk("uf_clear", 8'h02, 32'd1);

        // Frame 2: fifo_used=24 allows only one burst in flight.
        fifo_used  = FU_W'(24);
        single_chk = 1'b1;
        pulse_fs();
        wait_frame("f2_done");
        single_chk = 1'b0;
        csr_rd_chk("f2_fcnt", 8'h03, 32'd2);

        // Frame 3: fifo_used=25 blocks all requests; then 5-cycle waitrequest stall.
        fifo_used = FU_W'(25);
        pulse_fs();
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (av_read) seen++;
        end
        check_val("full_no_req", 32'(seen), 32'd0);
        stall     = 5;
        fifo_used = '0;
        wait_frame("f3_done");
        check_val("stall_used", 32'(stall), 32'd0);
        csr_rd_chk("f3_fcnt", 8'h03, 32'd2 + 32'd1);

        // Frame 4: slow slave, base flip mid-frame, restart with 16 beats in flight.
        lat       = 20;
        fifo_used = FU_W'(9);
        pulse_fs();
        wait_outstanding("f4_first_burst", 8, 16);
        csr_wr(8'h01, 32'h0000_8000);
        wait_outstanding("f4_two_bursts", 16, 16);
        d0 = disc_cnt;
        pulse_fs();
        lat       = 2;
        fifo_used = '0;
        wait_frame("f5_done");
        check_val("f4_discarded", 32'(disc_cnt - d0), 32'd16);
        check_val("f5_flush", 32'(flush_cnt), 32'd5);
        csr_rd_chk("f5_fcnt", 8'h03, 32'd4);

        // Frame 6: enable cleared mid-frame; outstanding beats drain, then IDLE.
        lat       = 20;
        fifo_used = FU_W'(9);
        pulse_fs();
        wait_outstanding("f6_two_bursts", 16, 16);
        csr_wr(8'h00, 32'd0);
        wait_outstanding("f6_drained", 0, 0);
        repeat (4) @(negedge clk);
        check_val("f6_grants", 32'(grants_ep), 32'd2);
        check_val("f6_flush",  32'(flush_cnt), 32'd6);
        csr_rd_chk("f6_status", 8'h02, 32'd0);
        csr_rd_chk("f6_fcnt",   8'h03, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
